traffic_ctrl_param: RTL and testbench

Parametrised, sensor-actuated two-way intersection controller with min/max green timing, all-red clearance and an optional pedestrian walk phase. It is the next-generation replacement for the fixed-timing 4-state traffic FSM in `fsm_traffic_light`. All phase durations come from parameters, and both approaches are actuated symmetrically. Lamp outputs drive the intersection signal heads directly.

---
 rtl/traffic_ctrl_param.sv | 137 +++++++++++++
 tb/tb_traffic_ctrl_param.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/traffic_ctrl_param.sv
// traffic_ctrl_param: sensor-actuated two-way intersection controller with min/max green,
// yellow, all-red clearance. Optional pedestrian walk phase is enabled by TRAFFIC_PED_EN.
module traffic_ctrl_param #(
  parameter int unsigned GREEN_MIN = 4,
  parameter int unsigned GREEN_MAX = 10,
  parameter int unsigned YELLOW_T  = 3,
  parameter int unsigned ALLRED_T  = 1,
  parameter int unsigned WALK_T    = 5,
  parameter int unsigned TIMER_W   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ns_sensor,
  input  logic       ew_sensor,
  input  logic       ped_req,
  output logic       ns_red,
  output logic       ns_yel,
  output logic       ns_grn,
  output logic       ew_red,
  output logic       ew_yel,
  output logic       ew_grn,
  output logic       walk,
  output logic       ped_wait,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    AR_TO_EW  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    AR_TO_NS  = 3'd5,
    PED_WALK  = 3'd6
  } state_e;

  localparam logic [TIMER_W-1:0] GMIN_M1 = TIMER_W'(GREEN_MIN - 1);
  localparam logic [TIMER_W-1:0] GMAX_M1 = TIMER_W'(GREEN_MAX - 1);
  localparam logic [TIMER_W-1:0] YEL_M1  = TIMER_W'(YELLOW_T - 1);
  localparam logic [TIMER_W-1:0] AR_M1   = TIMER_W'(ALLRED_T - 1);
  localparam logic [TIMER_W-1:0] WALK_M1 = TIMER_W'(WALK_T - 1);

  state_e             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               ped_pending;

`ifdef TRAFFIC_PED_EN
  logic ped_wait_q, ped_wait_d;
  logic dir_ew_q, dir_ew_d;
  logic enter_walk;

  assign ped_pending = ped_wait_q;
  assign ped_wait    = ped_wait_q;
  assign walk        = (state_q == PED_WALK);
`else
  logic [TIMER_W:0] ped_unused;

  assign ped_unused  = {ped_req, WALK_M1};
  assign ped_pending = 1'b0;
  assign ped_wait    = 1'b0;
  assign walk        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      NS_GREEN:  if ((timer_q >= GMIN_M1 && (ew_sensor || ped_pending)) || timer_q == GMAX_M1)
                   state_d = NS_YELLOW;
      NS_YELLOW: if (timer_q == YEL_M1) state_d = AR_TO_EW;
      AR_TO_EW:  if (timer_q == AR_M1) state_d = ped_pending ? PED_WALK : EW_GREEN;
      EW_GREEN:  if ((timer_q >= GMIN_M1 && (ns_sensor || ped_pending)) || timer_q == GMAX_M1)
                   state_d = EW_YELLOW;
      EW_YELLOW: if (timer_q == YEL_M1) state_d = AR_TO_NS;
      AR_TO_NS:  if (timer_q == AR_M1) state_d = ped_pending ? PED_WALK : NS_GREEN;
`ifdef TRAFFIC_PED_EN
      PED_WALK:  if (timer_q == WALK_M1) state_d = dir_ew_q ? EW_GREEN : NS_GREEN;
`endif
      default:   state_d = NS_GREEN;
    endcase
    // every transition restarts the phase timer; green exits at GREEN_MAX-1 so it never wraps
    timer_d = (state_d != state_q) ? '0 : timer_q + TIMER_W'(1);
  end

`ifdef TRAFFIC_PED_EN
  // clear on walk entry takes priority over a request sampled on the same edge
  always_comb begin
    enter_walk = (state_d == PED_WALK) && (state_q != PED_WALK);
    dir_ew_d   = dir_ew_q;
    ped_wait_d = ped_wait_q;
    if (enter_walk) begin
      dir_ew_d   = (state_q == AR_TO_EW);
      ped_wait_d = 1'b0;
    end else if (ped_req) begin
      ped_wait_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ped_wait_q <= 1'b0;
      dir_ew_q   <= 1'b1;
    end else begin
      ped_wait_q <= ped_wait_d;
      dir_ew_q   <= dir_ew_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= NS_GREEN;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    ns_red = 1'b1;
    ns_yel = 1'b0;
    ns_grn = 1'b0;
    ew_red = 1'b1;
    ew_yel = 1'b0;
    ew_grn = 1'b0;
    case (state_q)
      NS_GREEN:  begin ns_red = 1'b0; ns_grn = 1'b1; end
      NS_YELLOW: begin ns_red = 1'b0; ns_yel = 1'b1; end
      EW_GREEN:  begin ew_red = 1'b0; ew_grn = 1'b1; end
      EW_YELLOW: begin ew_red = 1'b0; ew_yel = 1'b1; end
      default:   ;
    endcase
  end

  assign phase = state_q;

endmodule

// File: tb/tb_traffic_ctrl_param.sv
// Bench for traffic_ctrl_param: duration-based phase model checked every cycle,
// plus literal expectations from hand-computed timelines.
module tb_traffic_ctrl_param;
  localparam int GMIN = 4;
  localparam int GMAX = 8;
  localparam int YEL  = 2;
  localparam int AR   = 1;
  localparam int WALK = 3;
`ifdef TRAFFIC_PED_EN
  localparam bit PE = 1'b1;
`else
  localparam bit PE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ns_sensor = 1'b0;
  logic ew_sensor = 1'b0;
  logic ped_req = 1'b0;
  logic ns_red, ns_yel, ns_grn, ew_red, ew_yel, ew_grn, walk, ped_wait;
  logic [2:0] phase;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  traffic_ctrl_param #(
    .GREEN_MIN(GMIN), .GREEN_MAX(GMAX), .YELLOW_T(YEL),
    .ALLRED_T(AR), .WALK_T(WALK), .TIMER_W(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ns_sensor(ns_sensor), .ew_sensor(ew_sensor),
    .ped_req(ped_req), .ns_red(ns_red), .ns_yel(ns_yel), .ns_grn(ns_grn),
    .ew_red(ew_red), .ew_yel(ew_yel), .ew_grn(ew_grn), .walk(walk),
    .ped_wait(ped_wait), .phase(phase)
  );

  always #5 clk = ~clk;

  // Phase model: m_ph is the phase number, m_el the count of cycles already spent in it (1-based).
  int m_ph = 0;
  int m_el = 1;
  bit m_ped = 1'b0;
  bit m_to_ew = 1'b1;

  always @(posedge clk) begin : model
    int nx;
    bit nped;
    bit ndir;
    nx = m_ph;
    nped = m_ped;
    ndir = m_to_ew;
    case (m_ph)
      0: if ((m_el >= GMIN && (ew_sensor || m_ped)) || m_el == GMAX) nx = 1;
      1: if (m_el == YEL) nx = 2;
      2: if (m_el == AR) nx = m_ped ? 6 : 3;
      3: if ((m_el >= GMIN && (ns_sensor || m_ped)) || m_el == GMAX) nx = 4;
      4: if (m_el == YEL) nx = 5;
      5: if (m_el == AR) nx = m_ped ? 6 : 0;
      6: if (m_el == WALK) nx = m_to_ew ? 3 : 0;
      default: nx = 0;
    endcase
    if (nx == 6 && m_ph != 6) begin
      nped = 1'b0;
      ndir = (m_ph == 2);
    end else if (PE && ped_req) begin
      nped = 1'b1;
    end
    if (!rst_n) begin
      m_ph <= 0; m_el <= 1; m_ped <= 1'b0; m_to_ew <= 1'b1;
    end else begin
      m_ph <= nx;
      m_el <= (nx == m_ph) ? m_el + 1 : 1;
      m_ped <= nped;
      m_to_ew <= ndir;
    end
  end

  function automatic logic [6:0] lamps(input int p);
    case (p)
      0: return 7'b0011000;
      1: return 7'b0101000;
      3: return 7'b1000010;
      4: return 7'b1000100;
      6: return 7'b1001001;
      default: return 7'b1001000;
    endcase
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      logic [10:0] got, want;
      got  = {ns_red, ns_yel, ns_grn, ew_red, ew_yel, ew_grn, walk, ped_wait, phase};
      want = {lamps(m_ph), PE ? m_ped : 1'b0, 3'(m_ph)};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL model t=%0t got=%b want=%b", $time, got, want);
      end
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; ns_sensor = 1'b0; ew_sensor = 1'b0; ped_req = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic edge1();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // reset / idle, then mid-phase reset during EW yellow
    do_reset();
    chk_en = 1'b1;
    chk("rst_lamps", 32'({ns_red, ns_yel, ns_grn, ew_red, ew_yel, ew_grn, walk}), 32'b0011000);
    chk("rst_phase", 32'(phase), 0);
    chk("rst_ped_wait", 32'(ped_wait), 0);
    for (int k = 1; k <= 20; k++) begin
      edge1();
      if (k == 7)  chk("idle_ns_grn_k7", 32'(ns_grn), 1);
      if (k == 8)  chk("idle_ns_yel_k8", 32'(ns_yel), 1);
      if (k == 10) chk("idle_allred_k10", 32'({ns_red, ew_red, ns_grn, ew_grn}), 32'b1100);
      if (k == 11) chk("idle_ew_grn_k11", 32'(ew_grn), 1);
      if (k == 20) chk("idle_ew_yel_t1", 32'(phase), 4);
    end
    rst_n = 1'b0;
    edge1();
    chk("midrst_phase", 32'(phase), 0);
    chk("midrst_lamps", 32'({ns_grn, ew_red, ped_wait}), 32'b110);
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      edge1();
      if (k == 7) chk("midrst_ns_grn_k7", 32'(ns_grn), 1);
      if (k == 8) chk("midrst_ns_yel_k8", 32'(ns_yel), 1);
    end

    // continuous demand on both approaches: strict alternation, period 14
    do_reset();
    ns_sensor = 1'b1; ew_sensor = 1'b1;
    for (int k = 1; k <= 28; k++) begin
      edge1();
      if (k == 3)  chk("dem_ns_grn_k3", 32'(ns_grn), 1);
      if (k == 4)  chk("dem_ns_yel_k4", 32'(ns_yel), 1);
      if (k == 6)  chk("dem_allred_k6", 32'({ns_red, ew_red}), 3);
      if (k == 7)  chk("dem_ew_grn_k7", 32'(ew_grn), 1);
      if (k == 10) chk("dem_ew_grn_k10", 32'(ew_grn), 1);
      if (k == 11) chk("dem_ew_yel_k11", 32'(ew_yel), 1);
      if (k == 14) chk("dem_ns_grn_k14", 32'(ns_grn), 1);
      if (k == 28) chk("dem_ns_grn_k28", 32'(ns_grn), 1);
    end

    // sensor pulses that drop before minimum green, mixed with ped_req toggling
    do_reset();
    for (int k = 1; k <= 60; k++) begin
      ew_sensor = (k % 11 == 2) || (k % 11 == 7);
      ns_sensor = (k % 13 >= 9);
      ped_req = PE ? (k % 23 == 5) : k[0];
      edge1();
      if (k == 4) chk("glitch_ns_grn_k4", 32'(ns_grn), 1);
    end
    ped_req = 1'b0; ns_sensor = 1'b0; ew_sensor = 1'b0;

`ifdef TRAFFIC_PED_EN
    // pedestrian pulse during NS green timer 1
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      edge1();
      ped_req = (k == 1);
      if (k == 2)  chk("ped_wait_set", 32'(ped_wait), 1);
      if (k == 3)  chk("ped_ns_grn_k3", 32'(ns_grn), 1);
      if (k == 4)  chk("ped_ns_yel_k4", 32'(ns_yel), 1);
      if (k == 7)  chk("ped_walk_k7", 32'({walk, ns_red, ew_red, ped_wait}), 32'b1110);
      if (k == 9)  chk("ped_walk_k9", 32'(walk), 1);
      if (k == 10) chk("ped_ew_grn_k10", 32'({ew_grn, walk}), 32'b10);
    end

    // request on the walk entry edge is absorbed by that walk
    do_reset();
    for (int k = 1; k <= 21; k++) begin
      edge1();
      ped_req = (k == 1) || (k == 6);
      if (k == 7)  chk("same_walk_k7", 32'({walk, ped_wait}), 32'b10);
      if (k == 8)  chk("same_ped_wait_k8", 32'(ped_wait), 0);
      if (k == 17) chk("same_ew_grn_k17", 32'(ew_grn), 1);
      if (k == 21) chk("same_ns_grn_k21", 32'({ns_grn, walk}), 32'b10);
    end
`else
    // pedestrian input must have no effect at all
    do_reset();
    for (int k = 1; k <= 24; k++) begin
      ped_req = k[0];
      edge1();
      if (k == 8)  chk("off_ns_yel_k8", 32'(ns_yel), 1);
      if (k == 11) chk("off_ew_grn_k11", 32'({ew_grn, walk, ped_wait}), 32'b100);
      if (phase == 3'd6) chk("off_phase6", 32'(phase), 0);
    end
    ped_req = 1'b0;
`endif

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
